// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad column scanner with 2-flop row sync.
// Optional ghost-frame rejection under macro KEYPAD_SCAN_GHOST_FILTER_EN.
// Ports: clk, reset (async, active-low), rows[3:0] (active-low pins),
//   col[3:0] (active-low drive), keys_pressed[15:0] (bit 4*c+r),
//   scan_done (1-cycle frame pulse), ghost (valid with scan_done).
module keypad_scanner #(
   parameter int SETTLE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  rows,
   output logic [3:0]  col,
   output logic [15:0] keys_pressed,
   output logic        scan_done,
   output logic        ghost
);

   localparam int CW = ($clog2(SETTLE_CYCLES) < 2) ? 2 : $clog2(SETTLE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {
      SETTLE,
      CAPTURE,
      PUBLISH
   } state_t;

   state_t        state;
   state_t        state_nx;
   logic [1:0]    c;
   logic [1:0]    c_nx;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nx;
   logic [15:0]   frame_buf;
   logic [15:0]   buf_nx;
   logic [3:0]    rows_meta;
   logic [3:0]    rows_sync;
   logic          publish;

   assign col     = ~(4'b0001 << c);
   assign publish = (state == PUBLISH);

   always_comb begin
      state_nx = state;
      c_nx     = c;
      cnt_nx   = cnt;
      buf_nx   = frame_buf;
      unique case (state)
         SETTLE: begin
            if (cnt == CNT_LAST) state_nx = CAPTURE;
            else                 cnt_nx   = cnt + 1'b1;
         end
         CAPTURE: begin
            buf_nx[{c, 2'b00} +: 4] = ~rows_sync;
            if (c != 2'd3) begin
               c_nx     = c + 2'd1;
               cnt_nx   = '0;
               state_nx = SETTLE;
            end else begin
               state_nx = PUBLISH;
            end
         end
         PUBLISH: begin
            c_nx     = 2'd0;
            cnt_nx   = '0;
            state_nx = SETTLE;
         end
         default: state_nx = SETTLE;
      endcase
   end

`ifdef KEYPAD_SCAN_GHOST_FILTER_EN
   // More than two keys in one frame may include phantom keys from
   // diode-less matrix paths, so such frames are not published.
   logic [4:0] ones;
   logic       reject;

   always_comb begin
      ones = '0;
      for (int i = 0; i < 16; i++) ones = ones + {4'd0, frame_buf[i]};
      reject = (ones > 5'd2);
   end
`else
   assign ghost = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rows_meta    <= 4'b1111;
         rows_sync    <= 4'b1111;
         state        <= SETTLE;
         c            <= 2'd0;
         cnt          <= '0;
         frame_buf    <= '0;
         keys_pressed <= '0;
         scan_done    <= 1'b0;
`ifdef KEYPAD_SCAN_GHOST_FILTER_EN
         ghost        <= 1'b0;
`endif
      end else begin
         rows_meta <= rows;
         rows_sync <= rows_meta;
         state     <= state_nx;
         c         <= c_nx;
         cnt       <= cnt_nx;
         frame_buf <= buf_nx;
         scan_done <= publish;
`ifdef KEYPAD_SCAN_GHOST_FILTER_EN
         ghost <= publish && reject;
         if (publish && !reject) keys_pressed <= frame_buf;
`else
         if (publish) keys_pressed <= frame_buf;
`endif
      end
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: scoreboard bench for keypad_scanner (SETTLE_CYCLES=4).
// Rows are modelled combinationally from col and a pressed-key set.
module tb_keypad_scanner;

   logic        clk;
   logic        reset;
   logic [3:0]  rows;
   logic [3:0]  col;
   logic [15:0] keys_pressed;
   logic        scan_done;
   logic        ghost;

   logic [15:0] press;
   int          cyc;
   int          fno;
   int          tests;
   int          fails;

   typedef struct packed {
      logic [15:0] keys;
      logic        gh;
      logic [31:0] cyc;
   } exp_t;

   exp_t q[$];

   keypad_scanner #(.SETTLE_CYCLES(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .rows         (rows),
      .col          (col),
      .keys_pressed (keys_pressed),
      .scan_done    (scan_done),
      .ghost        (ghost)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      rows = 4'hF;
      for (int i = 0; i < 4; i++)
         if (col[i] == 1'b0) rows = rows & ~press[4*i +: 4];
   end

   always @(posedge clk or negedge reset)
      if (!reset) cyc <= 0;
      else        cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push(input logic [15:0] k, input logic g);
      exp_t e;
      fno++;
      e.keys = k;
      e.gh   = g;
      e.cyc  = 32'(21 * fno);
      q.push_back(e);
   endtask

   task automatic wait_sd();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!scan_done && n < 30);
      if (!scan_done) begin
         tests++;
         fails++;
         $display("FAIL scan_done_timeout: got none expected pulse within 30");
      end
   endtask

   task automatic wait_col(input logic [3:0] want);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (col != want && n < 30);
      if (col != want) begin
         tests++;
         fails++;
         $display("FAIL col_timeout: got %b expected %b", col, want);
      end
   endtask

   task automatic frame(input logic [15:0] p, input logic [15:0] k,
                        input logic g);
      press = p;
      push(k, g);
      wait_sd();
   endtask

   // monitor: every published frame is matched against the scoreboard
   always @(negedge clk) begin
      exp_t e;
      if (reset && scan_done) begin
         if (q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_scan_done: got pulse expected none");
         end else begin
            e = q.pop_front();
            check("keys_pressed", 32'(keys_pressed), 32'(e.keys));
            check("ghost", 32'(ghost), 32'(e.gh));
            check("frame_cycle", 32'(cyc), e.cyc);
         end
      end
   end

   initial begin
      logic [3:0] ecol;
      int         pos;
      tests = 0;
      fails = 0;
      fno   = 0;
      press = '0;
      reset = 1'b0;

      repeat (10) begin
         @(negedge clk);
         check("reset_col", 32'(col), 32'(4'b1110));
         check("reset_keys", 32'(keys_pressed), 32'h0);
         check("reset_scan_done", 32'(scan_done), 32'h0);
      end

      push(16'h0000, 1'b0);
      reset = 1'b1;

      for (int p = 1; p <= 21; p++) begin
         @(negedge clk);
         pos  = (p < 20) ? p / 5 : ((p == 20) ? 3 : 0);
         ecol = 4'b1110;
         case (pos)
            1: ecol = 4'b1101;
            2: ecol = 4'b1011;
            3: ecol = 4'b0111;
            default: ecol = 4'b1110;
         endcase
         check("col_sequence", 32'(col), 32'(ecol));
         if (p < 21) check("no_early_scan_done", 32'(scan_done), 32'h0);
      end

      frame(16'h0000, 16'h0000, 1'b0);
      frame(16'h0200, 16'h0200, 1'b0);
      frame(16'h0000, 16'h0000, 1'b0);
      frame(16'h8001, 16'h8001, 1'b0);
      frame(16'h0000, 16'h0000, 1'b0);
`ifdef KEYPAD_SCAN_GHOST_FILTER_EN
      frame(16'h0013, 16'h0000, 1'b1);
`else
      frame(16'h0013, 16'h0013, 1'b0);
`endif
      frame(16'h0000, 16'h0000, 1'b0);

      // late row change: two cycles before column 1 capture
      press = 16'h0010;
      push(16'h0010, 1'b0);
      push(16'h0040, 1'b0);
      wait_col(4'b1101);
      repeat (3) @(posedge clk);
      #1 press = 16'h0040;
      wait_sd();
      wait_sd();

      // reset during column 2 capture
      press = 16'h0010;
      wait_col(4'b1011);
      repeat (4) @(posedge clk);
      #1 reset = 1'b0;
      #1;
      check("midreset_col", 32'(col), 32'(4'b1110));
      check("midreset_keys", 32'(keys_pressed), 32'h0);
      check("midreset_scan_done", 32'(scan_done), 32'h0);
      check("midreset_ghost", 32'(ghost), 32'h0);
      repeat (3) @(negedge clk);
      fno = 0;
      push(16'h0010, 1'b0);
      reset = 1'b1;
      wait_sd();
      frame(16'h0000, 16'h0000, 1'b0);

      @(negedge clk);
      check("scoreboard_drained", 32'(q.size()), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
